// File: rtl/fc_batch_sequencer.sv
// fc_batch_sequencer: batch-level control for a chain of fully connected layer engines.
// Latency: start -> layer_start_o[0] one cycle; layer done -> next layer start one cycle;
//          final done -> res_valid_o one cycle (NUM_OUT+1 cycles with FC_SEQ_ARGMAX_EN).
// Backpressure: a result is held on res_valid_o/res_data_o until res_ready_i; the next sample
//          is not launched before acceptance.
//
// Optional feature macro: FC_SEQ_ARGMAX_EN (adds an ARGMAX scan state driving res_class_o).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i, abort_i              batch start pulse, batch abandon
//   busy_o, done_o, err_o         batch in progress, batch-complete pulse, sticky protocol error
//   layer_start_o, layer_done_i   one-hot start pulses / done pulses, one bit per layer engine
//   sample_idx_o, in_base_addr_o  current sample and its input RAM base address
//   res_en_i/res_addr_i/res_data_i  final-layer output writes into the result buffer
//   res_valid_o/res_ready_i       result handshake; res_idx_o, res_data_o, res_class_o are payload
module fc_batch_sequencer #(
   parameter int NUM_LAYERS        = 3,
   parameter int NUM_SAMPLES       = 42,
   parameter int BLOCKS_PER_SAMPLE = 4,
   parameter int ADDR_W            = 8,
   parameter int CNT_W             = 8,
   parameter int NUM_OUT           = 2,
   parameter int OUT_W             = 36
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         abort_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [NUM_LAYERS-1:0]        layer_start_o,
   input  logic [NUM_LAYERS-1:0]        layer_done_i,
   output logic [CNT_W-1:0]             sample_idx_o,
   output logic [ADDR_W-1:0]            in_base_addr_o,
   input  logic                         res_en_i,
   input  logic [$clog2(NUM_OUT)-1:0]   res_addr_i,
   input  logic signed [OUT_W-1:0]      res_data_i,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic [CNT_W-1:0]             res_idx_o,
   output logic [NUM_OUT*OUT_W-1:0]     res_data_o,
   output logic [$clog2(NUM_OUT)-1:0]   res_class_o
);

   localparam int RES_AW  = $clog2(NUM_OUT);
   localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
`ifdef FC_SEQ_ARGMAX_EN
      ST_ARGMAX = 3'd3,
`endif
      ST_EMIT   = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [LAYER_W-1:0]         layer_q;
   logic [CNT_W-1:0]           sample_q;
   logic [ADDR_W-1:0]          base_q;
   logic                       err_q;
   logic                       done_q;
   logic signed [OUT_W-1:0]    res_buf [NUM_OUT];

`ifdef FC_SEQ_ARGMAX_EN
   logic [RES_AW-1:0]          scan_q;
   logic [RES_AW-1:0]          best_idx_q;
   logic signed [OUT_W-1:0]    best_val_q;
   logic [RES_AW-1:0]          class_q;
   logic                       scan_last;
   logic                       scan_take;
   logic [RES_AW-1:0]          scan_next_idx;
`endif

   logic [NUM_LAYERS-1:0]      awaited_mask;
   logic                       in_wait;
   logic                       awaited_hit;
   logic                       stray;
   logic                       last_layer;
   logic                       last_sample;
   logic                       abort_hit;
   logic                       capture_en;

   assign awaited_mask = NUM_LAYERS'(1) << layer_q;
   assign in_wait      = (state_q == ST_WAIT);
   assign awaited_hit  = in_wait && ((layer_done_i & awaited_mask) != '0);
   // Only the awaited done bit is legal, and only while waiting for it.
   assign stray        = in_wait ? ((layer_done_i & ~awaited_mask) != '0)
                                 : (layer_done_i != '0);
   assign last_layer   = (layer_q == LAYER_W'(NUM_LAYERS - 1));
   assign last_sample  = (sample_q == CNT_W'(NUM_SAMPLES - 1));
   assign abort_hit    = abort_i && (state_q != ST_IDLE);
   // Includes the write landing in the same cycle as the final done.
   assign capture_en   = in_wait && last_layer && res_en_i;

`ifdef FC_SEQ_ARGMAX_EN
   assign scan_last     = (scan_q == RES_AW'(NUM_OUT - 1));
   // Strict greater-than keeps the lowest index on ties.
   assign scan_take     = (scan_q == '0) || (res_buf[scan_q] > best_val_q);
   assign scan_next_idx = scan_take ? scan_q : best_idx_q;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_WAIT;
         ST_WAIT: begin
            if (awaited_hit) begin
               if (!last_layer) state_d = ST_LAUNCH;
`ifdef FC_SEQ_ARGMAX_EN
               else             state_d = ST_ARGMAX;
`else
               else             state_d = ST_EMIT;
`endif
            end
         end
`ifdef FC_SEQ_ARGMAX_EN
         ST_ARGMAX: if (scan_last) state_d = ST_EMIT;
`endif
         ST_EMIT: begin
            if (res_ready_i) state_d = last_sample ? ST_IDLE : ST_LAUNCH;
         end
         default:   state_d = ST_IDLE;
      endcase
      if (abort_hit) state_d = ST_IDLE;
   end

   // Datapath: counters, error flag, result buffer, argmax scan
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         layer_q  <= '0;
         sample_q <= '0;
         base_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < NUM_OUT; i++) res_buf[i] <= '0;
`ifdef FC_SEQ_ARGMAX_EN
         scan_q     <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         class_q    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         // A new batch clears the flag; a stray bit in the same cycle still sets it.
         if (state_q == ST_IDLE && start_i) err_q <= stray;
         else                               err_q <= err_q | stray;

         if (abort_hit) begin
            layer_q  <= '0;
            sample_q <= '0;
            base_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     layer_q  <= '0;
                     sample_q <= '0;
                     base_q   <= '0;
                  end
               end
               ST_LAUNCH: begin
                  if (layer_q == '0)
                     for (int i = 0; i < NUM_OUT; i++) res_buf[i] <= '0;
               end
               ST_WAIT: begin
                  if (capture_en)
                     for (int i = 0; i < NUM_OUT; i++)
                        if (res_addr_i == RES_AW'(i)) res_buf[i] <= res_data_i;
                  if (awaited_hit && !last_layer) layer_q <= layer_q + LAYER_W'(1);
`ifdef FC_SEQ_ARGMAX_EN
                  scan_q <= '0;
`endif
               end
`ifdef FC_SEQ_ARGMAX_EN
               ST_ARGMAX: begin
                  best_val_q <= scan_take ? res_buf[scan_q] : best_val_q;
                  best_idx_q <= scan_next_idx;
                  scan_q     <= scan_q + RES_AW'(1);
                  if (scan_last) class_q <= scan_next_idx;
               end
`endif
               ST_EMIT: begin
                  if (res_ready_i) begin
                     if (last_sample) begin
                        done_q <= 1'b1;
                     end else begin
                        sample_q <= sample_q + CNT_W'(1);
                        // Running sum equals sample*BLOCKS_PER_SAMPLE modulo 2^ADDR_W.
                        base_q   <= base_q + ADDR_W'(BLOCKS_PER_SAMPLE);
                        layer_q  <= '0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs; result payload is zero whenever no result is presented.
   always_comb begin
      busy_o         = (state_q != ST_IDLE);
      done_o         = done_q;
      err_o          = err_q;
      layer_start_o  = (state_q == ST_LAUNCH) ? awaited_mask : '0;
      sample_idx_o   = sample_q;
      in_base_addr_o = base_q;
      res_valid_o    = (state_q == ST_EMIT);
      res_idx_o      = '0;
      res_data_o     = '0;
      res_class_o    = '0;
      if (state_q == ST_EMIT) begin
         res_idx_o = sample_q;
         for (int i = 0; i < NUM_OUT; i++) res_data_o[i*OUT_W +: OUT_W] = res_buf[i];
`ifdef FC_SEQ_ARGMAX_EN
         res_class_o = class_q;
`endif
      end
   end

endmodule

// File: tb/tb_fc_batch_sequencer.sv
`timescale 1ns/1ps
module tb_fc_batch_sequencer;
   localparam int NL  = 3;
   localparam int NS  = 2;
   localparam int BPS = 4;
   localparam int AW  = 8;
   localparam int CW  = 8;
   localparam int NO  = 2;
   localparam int OW  = 36;
   localparam int RAW = $clog2(NO);
`ifdef FC_SEQ_ARGMAX_EN
   localparam int LAT = NO + 1;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst, start, abort, res_en, res_ready;
   logic [NL-1:0] layer_done;
   logic [RAW-1:0] res_addr;
   logic signed [OW-1:0] res_data;
   logic busy_o, done_o, err_o, res_valid_o;
   logic [NL-1:0] layer_start_o;
   logic [CW-1:0] sample_idx_o, res_idx_o;
   logic [AW-1:0] in_base_addr_o;
   logic [NO*OW-1:0] res_data_o;
   logic [RAW-1:0] res_class_o;

   int n_total = 0;
   int n_pass  = 0;
   logic signed [OW-1:0] exp_buf [NO];

   fc_batch_sequencer #(
      .NUM_LAYERS(NL), .NUM_SAMPLES(NS), .BLOCKS_PER_SAMPLE(BPS), .ADDR_W(AW),
      .CNT_W(CW), .NUM_OUT(NO), .OUT_W(OW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .layer_start_o(layer_start_o), .layer_done_i(layer_done),
      .sample_idx_o(sample_idx_o), .in_base_addr_o(in_base_addr_o),
      .res_en_i(res_en), .res_addr_i(res_addr), .res_data_i(res_data),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready),
      .res_idx_o(res_idx_o), .res_data_o(res_data_o), .res_class_o(res_class_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: result vector is the last final-layer write per address, zero otherwise.
   function automatic logic [NO*OW-1:0] exp_pack();
      logic [NO*OW-1:0] p;
      for (int i = 0; i < NO; i++) p[i*OW +: OW] = exp_buf[i];
      return p;
   endfunction

   function automatic logic [RAW-1:0] exp_class();
      int best;
      best = 0;
`ifdef FC_SEQ_ARGMAX_EN
      for (int i = 1; i < NO; i++) if (exp_buf[i] > exp_buf[best]) best = i;
`endif
      return RAW'(best);
   endfunction

   function automatic logic [OW-1:0] rand_data();
      logic [63:0] r;
      logic signed [3:0] s;
      r = {$urandom(), $urandom()};
      s = r[3:0];
      if (r[40]) return {{(OW-4){s[3]}}, s};
      return r[OW-1:0];
   endfunction

   task automatic start_batch();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++;
      if (busy_o !== 1'b1) $display("FAIL start_busy: got %b want 1", busy_o);
      else n_pass++;
   endtask

   // Caller leaves the bench in the cycle where layer_start_o[0] of this sample should show.
   // mode 0: random writes/ready noise, 1: -5@0 then +7@1 with final done, 2: -5/-5, 3: no writes.
   task automatic do_sample(input int sidx, input int mode, input int hold, input bit stop_in_emit);
      int d;
      logic [NL-1:0] want;
      for (int l = 0; l < NL; l++) begin
         want = NL'(1) << l;
         n_total++;
         if (layer_start_o !== want)
            $display("FAIL launch s%0d l%0d: got %b want %b", sidx, l, layer_start_o, want);
         else n_pass++;
         n_total++;
         if ({sample_idx_o, in_base_addr_o} !== {CW'(sidx), AW'(sidx * BPS)})
            $display("FAIL sample_addr s%0d l%0d: got idx %0d base %0d want %0d %0d",
                     sidx, l, sample_idx_o, in_base_addr_o, sidx, sidx * BPS);
         else n_pass++;
         if (l == 0) for (int i = 0; i < NO; i++) exp_buf[i] = '0;
         if (mode == 0) begin   // writes during LAUNCH are ignored
            res_en = 1'($urandom_range(0, 1));
            res_addr = RAW'($urandom_range(0, NO - 1));
            res_data = rand_data();
         end
         tick();
         res_en = 1'b0;
         d = (mode == 0) ? $urandom_range(0, 3) : 1;
         for (int c = 0; c <= d; c++) begin
            if (mode == 0) begin
               res_ready = 1'($urandom_range(0, 1));
               res_en = 1'($urandom_range(0, 1));
               res_addr = RAW'($urandom_range(0, NO - 1));
               res_data = rand_data();
               if (res_en && l == NL - 1) exp_buf[res_addr] = res_data;
            end else if (l == NL - 1 && (mode == 1 || mode == 2)) begin
               res_en = 1'b1;
               res_addr = (c == 0) ? RAW'(0) : RAW'(1);
               res_data = (c == 0 || mode == 2) ? -36'sd5 : 36'sd7;
               exp_buf[res_addr] = res_data;
            end
            if (c == d) layer_done = want;
            tick();
            res_en = 1'b0; res_ready = 1'b0; layer_done = '0;
            if (c < d) begin
               n_total++;
               if ({res_valid_o, layer_start_o} !== '0)
                  $display("FAIL wait_quiet s%0d l%0d: got valid %b start %b want 0 0",
                           sidx, l, res_valid_o, layer_start_o);
               else n_pass++;
            end
         end
      end
      for (int k = 1; k < LAT; k++) begin
         n_total++;
         if (res_valid_o !== 1'b0) $display("FAIL latency_early s%0d: valid at +%0d want 0", sidx, k);
         else n_pass++;
         tick();
      end
      n_total++;
      if (res_valid_o !== 1'b1) $display("FAIL res_valid s%0d: got %b want 1", sidx, res_valid_o);
      else n_pass++;
      n_total++;
      if (res_idx_o !== CW'(sidx)) $display("FAIL res_idx s%0d: got %0d want %0d", sidx, res_idx_o, sidx);
      else n_pass++;
      n_total++;
      if (res_data_o !== exp_pack())
         $display("FAIL res_data s%0d: got %h want %h", sidx, res_data_o, exp_pack());
      else n_pass++;
      n_total++;
      if (res_class_o !== exp_class())
         $display("FAIL res_class s%0d: got %0d want %0d", sidx, res_class_o, exp_class());
      else n_pass++;
      if (stop_in_emit) return;
      for (int h = 0; h < hold; h++) begin
         res_en = 1'($urandom_range(0, 1));   // writes in EMIT are ignored
         res_addr = RAW'($urandom_range(0, NO - 1));
         res_data = rand_data();
         tick();
         res_en = 1'b0;
         n_total++;
         if ({res_valid_o, layer_start_o, res_idx_o, res_data_o} !== {1'b1, NL'(0), CW'(sidx), exp_pack()})
            $display("FAIL hold s%0d c%0d: got v%b st%b idx%0d data %h want v1 st0 idx%0d data %h",
                     sidx, h, res_valid_o, layer_start_o, res_idx_o, res_data_o, sidx, exp_pack());
         else n_pass++;
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      if (sidx == NS - 1) begin
         n_total++;
         if ({done_o, busy_o, res_valid_o} !== 3'b100)
            $display("FAIL batch_done: got done %b busy %b valid %b want 1 0 0", done_o, busy_o, res_valid_o);
         else n_pass++;
         tick();
         n_total++;
         if (done_o !== 1'b0) $display("FAIL done_pulse: got %b want 0", done_o);
         else n_pass++;
      end else begin
         n_total++;
         if (done_o !== 1'b0) $display("FAIL early_done s%0d: got %b want 0", sidx, done_o);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_total++;
      if ({busy_o, done_o, err_o, layer_start_o, sample_idx_o, in_base_addr_o,
           res_valid_o, res_idx_o, res_data_o, res_class_o} !== '0)
         $display("FAIL reset_outputs: got busy %b err %b start %b valid %b data %h want all 0",
                  busy_o, err_o, layer_start_o, res_valid_o, res_data_o);
      else n_pass++;
   endtask

   task automatic test_random_batches();
      for (int b = 0; b < 4; b++) begin
         start_batch();
         do_sample(0, 0, $urandom_range(0, 3), 1'b0);
         do_sample(1, 0, $urandom_range(0, 3), 1'b0);
      end
   endtask

   task automatic test_backpressure();
      start_batch();
      do_sample(0, 0, 10, 1'b0);
      n_total++;
      if ({layer_start_o, in_base_addr_o} !== {NL'(1), AW'(BPS)})
         $display("FAIL bp_advance: got start %b base %0d want 001 %0d", layer_start_o, in_base_addr_o, BPS);
      else n_pass++;
      do_sample(1, 0, 2, 1'b0);
   endtask

   task automatic test_capture_signed();
      start_batch();
      do_sample(0, 1, 0, 1'b0);
      do_sample(1, 2, 1, 1'b0);
   endtask

   task automatic test_stray_err();
      layer_done = 3'b010;   // outside WAIT
      tick();
      layer_done = '0;
      n_total++;
      if ({err_o, busy_o} !== 2'b10) $display("FAIL err_idle: got err %b busy %b want 1 0", err_o, busy_o);
      else n_pass++;
      start_batch();
      n_total++;
      if ({err_o, layer_start_o} !== {1'b0, NL'(1)})
         $display("FAIL err_clear: got err %b start %b want 0 001", err_o, layer_start_o);
      else n_pass++;
      tick();
      layer_done = 3'b100;   // wrong layer while waiting for layer 0
      tick();
      layer_done = '0;
      n_total++;
      if ({err_o, busy_o, layer_start_o} !== {2'b11, NL'(0)})
         $display("FAIL err_wait: got err %b busy %b start %b want 1 1 000", err_o, busy_o, layer_start_o);
      else n_pass++;
      layer_done = 3'b001;
      tick();
      layer_done = '0;
      n_total++;
      if (layer_start_o !== 3'b010) $display("FAIL err_nochange: got %b want 010", layer_start_o);
      else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_total++;
      if ({err_o, busy_o} !== 2'b10) $display("FAIL err_kept_abort: got err %b busy %b want 1 0", err_o, busy_o);
      else n_pass++;
   endtask

   task automatic test_abort();
      int dones;
      start_batch();
      do_sample(0, 1, 0, 1'b0);
      tick();
      layer_done = 3'b001;
      tick();
      layer_done = '0;
      tick();   // WAIT for layer 1 of sample 1
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_total++;
      if ({busy_o, done_o, layer_start_o, sample_idx_o, in_base_addr_o, res_valid_o} !== '0)
         $display("FAIL abort_idle: got busy %b done %b start %b idx %0d base %0d valid %b want all 0",
                  busy_o, done_o, layer_start_o, sample_idx_o, in_base_addr_o, res_valid_o);
      else n_pass++;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
         tick();
      end
      n_total++;
      if (dones !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
      else n_pass++;
      start_batch();
      do_sample(0, 3, 0, 1'b0);   // no writes: buffer must read back as cleared
      do_sample(1, 0, 1, 1'b0);
   endtask

   task automatic test_reset_in_emit();
      start_batch();
      do_sample(0, 1, 0, 1'b1);
      layer_done = 3'b001;   // stray in EMIT
      tick();
      layer_done = '0;
      n_total++;
      if ({err_o, res_valid_o} !== 2'b11) $display("FAIL err_emit: got err %b valid %b want 1 1", err_o, res_valid_o);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_total++;
      if ({busy_o, done_o, err_o, layer_start_o, sample_idx_o, in_base_addr_o,
           res_valid_o, res_idx_o, res_data_o, res_class_o} !== '0)
         $display("FAIL reset_emit: got busy %b err %b valid %b data %h want all 0",
                  busy_o, err_o, res_valid_o, res_data_o);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_start_while_busy();
      start_batch();
      tick();
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if ({layer_start_o, sample_idx_o} !== '0)
            $display("FAIL start_busy_ignored c%0d: got start %b idx %0d want 000 0", i, layer_start_o, sample_idx_o);
         else n_pass++;
      end
      start = 1'b0;
      layer_done = 3'b001;
      tick();
      layer_done = '0;
      n_total++;
      if (layer_start_o !== 3'b010) $display("FAIL start_busy_progress: got %b want 010", layer_start_o);
      else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; res_en = 1'b0; res_ready = 1'b0;
      layer_done = '0; res_addr = '0; res_data = '0;
      test_reset();
      test_random_batches();
      test_backpressure();
      test_capture_signed();
      test_stray_err();
      test_abort();
      test_reset_in_emit();
      test_start_while_busy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fc_batch_sequencer.md
# fc_batch_sequencer

Parametrised successor to the fixed three-layer FC top-level control. Drives a chain of `NUM_LAYERS` fully connected layer engines through start/done pulses, iterating over `NUM_SAMPLES` input samples and producing the per-sample input RAM base address. It captures the final layer's output writes into a result buffer and presents each sample's result on a valid/ready port. The next sample is not launched until the current result is accepted, replacing the old free-running done-to-start loop.

## Interface
Parameters:
- `NUM_LAYERS`, 3: layer engines in the chain (≥1)
- `NUM_SAMPLES`, 42: samples per batch (≥1)
- `BLOCKS_PER_SAMPLE`, 4: input RAM words per sample
- `ADDR_W`, 8: input RAM address width
- `CNT_W`, 8: sample counter width
- `NUM_OUT`, 2: final-layer outputs per sample (≥2)
- `OUT_W`, 36: signed final output width

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock
- `rst_i` in 1: synchronous active-high reset
- `start_i` in 1: batch start pulse
- `abort_i` in 1: abandon batch
- `busy_o` out 1: batch in progress
- `done_o` out 1: one-cycle pulse, batch complete
- `err_o` out 1: sticky protocol error
- `layer_start_o` out NUM_LAYERS: one-hot start pulse per layer
- `layer_done_i` in NUM_LAYERS: per-layer done pulse
- `sample_idx_o` out CNT_W: current sample index
- `in_base_addr_o` out ADDR_W: sample_idx_o × BLOCKS_PER_SAMPLE, truncated to ADDR_W
- `res_en_i` in 1: final layer output write enable
- `res_addr_i` in $clog2(NUM_OUT): final layer output address
- `res_data_i` in OUT_W: final layer output data, signed
- `res_valid_o` out 1: result valid
- `res_ready_i` in 1: result accepted
- `res_idx_o` out CNT_W: sample index of the presented result
- `res_data_o` out NUM_OUT×OUT_W: packed results; entry 0 is in the LSBs
- `res_class_o` out $clog2(NUM_OUT): argmax index (see Configuration)

## Operation
- States: IDLE, LAUNCH, WAIT, ARGMAX (only when the Configuration macro is defined), EMIT.
- IDLE: on `start_i`, clear `sample_idx`, layer pointer, and `err_o`, then go to LAUNCH.
- LAUNCH: pulse `layer_start_o[layer]` for one cycle, then go to WAIT. When layer = 0, also clear the result buffer to zero.
- WAIT: on `layer_done_i[layer]`:
  - if layer < NUM_LAYERS−1: layer++, go to LAUNCH;
  - otherwise: go to ARGMAX, or to EMIT when ARGMAX is compiled out.
- Capture: `res_en_i` writes `res_data_i` into `buf[res_addr_i]` only in WAIT with layer = NUM_LAYERS−1. This includes a write in the same cycle as the final `layer_done_i`. Writes at any other time are ignored.
- EMIT: hold `res_valid_o`=1 with stable `res_data_o`, `res_idx_o`, and `res_class_o` until `res_ready_i`. On acceptance:
  - if last sample: go to IDLE and pulse `done_o`;
  - otherwise: sample_idx++, layer=0, go to LAUNCH.
- `err_o` is sticky and set when either:
  - any `layer_done_i` bit is high other than the awaited one in WAIT, or
  - any bit is high outside WAIT.

  Stray done bits do not change state.
- `start_i` while busy is ignored.
- `abort_i` in any non-IDLE state: go to IDLE next cycle. No `done_o`, outputs are zeroed, and `err_o` is kept.
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset: state IDLE, all outputs 0, buffer cleared.
- `start_i` at cycle t → `layer_start_o[0]` at t+1.
- `layer_done_i[k]` at t (k not last) → `layer_start_o[k+1]` at t+1.
- Final `layer_done_i` at t → `res_valid_o` at t+1. With ARGMAX: at t+NUM_OUT+1.
- `res_ready_i` at t (valid high) → next `layer_start_o[0]` at t+1, or `done_o` at t+1 for the last sample.
- `res_ready_i` without `res_valid_o` is ignored.
- Priority: `rst_i` > `abort_i` > FSM transitions.
- `in_base_addr_o` and `sample_idx_o` change only on sample advance; they are stable for all layers of a sample.

## Configuration
- `FC_SEQ_ARGMAX_EN` defined:
  - ARGMAX state scans buf[0..NUM_OUT−1], one entry per cycle, as a signed compare.
  - Lowest index wins on ties.
  - The result is registered to `res_class_o` before EMIT.
- Undefined: no ARGMAX state, and `res_class_o` is tied to 0.

## Test plan
- NUM_LAYERS=3, NUM_SAMPLES=2: start → layer starts 0,1,2 in order, each one cycle after the previous done. `res_valid_o` follows the third done by 1 cycle. Two results with res_idx 0 and 1, then `done_o`.
- `res_ready_i` held low for 10 cycles in EMIT → no `layer_start_o`; `res_data_o` is stable. Ready → `layer_start_o[0]` the next cycle, and `in_base_addr_o` goes 0→4.
- Final-layer writes of −5 to addr 0 and +7 to addr 1, with the addr 1 write in the same cycle as the final done → `res_data_o` = {7, −5}. With ARGMAX: `res_class_o`=1 and latency 3. Writes of equal values −5/−5 → class 0.
- `layer_done_i[2]` pulsed while waiting for layer 0 → `err_o`=1, state unchanged. The next `start_i` from IDLE clears it.
- `abort_i` during WAIT of sample 1 → IDLE next cycle, no `done_o`. A new start restarts at sample 0 with a cleared buffer.
- `rst_i` asserted during EMIT → all outputs 0 the next cycle. `start_i` while busy has no effect.
